// File: rtl/ff_arb_pkg.sv
// Shared types and width helpers for the capture arbiter.
package ff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping around.
module rr_pick
    import ff_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [2*NUM_REQ-1:0] req_dbl;

    // Doubling the vector turns the wrap into a plain upward search from ptr.
    always_comb begin
        req_dbl   = {req, req};
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (req_dbl[i] && (i >= int'(ptr))) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/ff_capture_arbiter.sv
// Round-robin arbiter sharing one enable-gated capture register among NUM_REQ requesters.
//  state | meaning
//  IDLE  | waiting for a request; a capture may occur on any edge
//  HOLD  | data_o frozen for HOLD_CYCLES after a capture; requests ignored
module ff_capture_arbiter
    import ff_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = 1,
    parameter  int HOLD_CYCLES = 2,
    localparam int IDX_W       = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      enable_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [IDX_W-1:0]          owner_o,
    output logic                      busy_o
);

    localparam int              CNT_W     = idx_w(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    arb_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   ptr;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  data_sel;
    logic [NUM_REQ-1:0] ack_nxt;
    logic [IDX_W-1:0]   ptr_nxt;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (req_i),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IDX_W'(k)) data_sel = data_i[k*DATA_W +: DATA_W];
        end
        ack_nxt = NUM_REQ'(1) << gnt_idx;
        ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            data_o   <= '0;
            ack_o    <= '0;
            enable_o <= 1'b0;
            owner_o  <= '0;
            busy_o   <= 1'b0;
        end else begin
            ack_o    <= '0;
            enable_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        data_o   <= data_sel;
                        ack_o    <= ack_nxt;
                        enable_o <= 1'b1;
                        owner_o  <= gnt_idx;
                        ptr      <= ptr_nxt;
                        if (HOLD_CYCLES > 0) begin
                            state  <= HOLD;
                            cnt    <= HOLD_INIT;
                            busy_o <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_capture_arbiter.sv
// Directed bench for ff_capture_arbiter: a hold-2 instance and a back-to-back instance.
module tb_ff_capture_arbiter;

    typedef struct packed {
        logic [3:0] ack;
        logic [1:0] owner;
        logic [3:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic [3:0]  req_a, req_b;
    logic [3:0]  data_a;
    logic [15:0] data_b;
    logic [3:0]  a_ack, b_ack;
    logic        a_en, b_en, a_busy, b_busy;
    logic [0:0]  a_data;
    logic [3:0]  b_data;
    logic [1:0]  a_owner, b_owner;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ff_capture_arbiter #(.NUM_REQ(4), .DATA_W(1), .HOLD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .req_i(req_a), .data_i(data_a),
        .ack_o(a_ack), .enable_o(a_en), .data_o(a_data), .owner_o(a_owner), .busy_o(a_busy)
    );

    ff_capture_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .req_i(req_b), .data_i(data_b),
        .ack_o(b_ack), .enable_o(b_en), .data_o(b_data), .owner_o(b_owner), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [3:0] ack, input logic [1:0] own, input logic [3:0] d);
        exp_t e;
        e.ack = ack; e.owner = own; e.data = d;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] ack, input logic [1:0] own, input logic [3:0] d);
        exp_t e;
        e.ack = ack; e.owner = own; e.data = d;
        qb.push_back(e);
    endtask

    // One clock edge, then pop the scoreboards for any capture the DUTs reported.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (a_en === 1'b1) begin
            chk("a_capture_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_ack", 32'(a_ack), 32'(e.ack));
                chk("a_owner", 32'(a_owner), 32'(e.owner));
                chk("a_data", 32'(a_data), 32'(e.data));
            end
        end else begin
            chk("a_ack_idle", 32'(a_ack), 32'd0);
        end
        if (b_en === 1'b1) begin
            chk("b_capture_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_ack", 32'(b_ack), 32'(e.ack));
                chk("b_owner", 32'(b_owner), 32'(e.owner));
                chk("b_data", 32'(b_data), 32'(e.data));
            end
        end else begin
            chk("b_ack_idle", 32'(b_ack), 32'd0);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_ack"}, 32'(a_ack), 32'd0);
        chk({tag, "_en"}, 32'(a_en), 32'd0);
        chk({tag, "_data"}, 32'(a_data), 32'd0);
        chk({tag, "_owner"}, 32'(a_owner), 32'd0);
        chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        int idx;
        logic [3:0] oh;

        // Reset with random activity on the inputs
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        req_a = 4'($urandom); data_a = 4'($urandom);
        req_b = 4'($urandom); data_b = 16'($urandom);
        step(); step();
        chk_a_zero("rst");
        chk("rst_b_en", 32'(b_en), 32'd0);
        chk("rst_b_data", 32'(b_data), 32'd0);
        req_b = 4'b0000;
        rst_a_n = 1'b1; req_a = 4'b0000;
        step();
        chk_a_zero("post_rst");

        // Single request, held through the hold window
        req_a = 4'b0100; data_a = 4'b0100;
        push_a(4'b0100, 2'd2, 4'd1);
        step();
        chk("single_drained", 32'(qa.size()), 32'd0);
        chk("single_en", 32'(a_en), 32'd1);
        chk("single_busy", 32'(a_busy), 32'd1);
        step();
        chk("hold1_en", 32'(a_en), 32'd0);
        chk("hold1_busy", 32'(a_busy), 32'd1);
        step();
        chk("hold2_en", 32'(a_en), 32'd0);
        chk("hold2_busy", 32'(a_busy), 32'd0);
        push_a(4'b0100, 2'd2, 4'd1);
        step();
        chk("recapture_drained", 32'(qa.size()), 32'd0);
        chk("recapture_busy", 32'(a_busy), 32'd1);

        // Requester 3 asks only during the hold and then withdraws
        req_a = 4'b1000;
        step(); step();
        chk("wd_busy", 32'(a_busy), 32'd0);
        req_a = 4'b0000;
        step(); step();
        chk("wd_no_en", 32'(a_en), 32'd0);
        chk("idle_data_hold", 32'(a_data), 32'd1);
        chk("idle_owner_hold", 32'(a_owner), 32'd2);

        // ptr=3, only requester 0 pending: wrap to 0, ptr advances to 1
        req_a = 4'b0001; data_a = 4'b0001;
        push_a(4'b0001, 2'd0, 4'd1);
        step();
        chk("wrap_drained", 32'(qa.size()), 32'd0);
        req_a = 4'b0000;
        step(); step();
        req_a = 4'b0011; data_a = 4'b0010;
        push_a(4'b0010, 2'd1, 4'd1);
        step();
        chk("ptr1_drained", 32'(qa.size()), 32'd0);

        // Reset during the hold that follows requester 1's capture
        rst_a_n = 1'b0; req_a = 4'b0000;
        step();
        chk_a_zero("midhold_rst");
        rst_a_n = 1'b1; req_a = 4'b0011; data_a = 4'b0001;
        push_a(4'b0001, 2'd0, 4'd1);
        step();
        chk("after_rst_drained", 32'(qa.size()), 32'd0);
        req_a = 4'b0000;
        step(); step();

        // Fairness with all four requesting continuously
        rst_a_n = 1'b0;
        step();
        rst_a_n = 1'b1; req_a = 4'b1111; data_a = 4'b1010;
        for (int n = 0; n < 5; n++) begin
            idx = n % 4;
            oh = 4'(1) << idx;
            push_a(oh, 2'(idx), 4'(data_a[idx]));
            step();
            chk("fair_drained", 32'(qa.size()), 32'd0);
            chk("fair_busy", 32'(a_busy), 32'd1);
            step();
            chk("fair_gap1_en", 32'(a_en), 32'd0);
            step();
            chk("fair_gap2_en", 32'(a_en), 32'd0);
        end
        req_a = 4'b0000;
        step(); step(); step();
        chk("a_queue_empty", 32'(qa.size()), 32'd0);

        // Back-to-back captures with no hold
        rst_b_n = 1'b1; req_b = 4'b1010; data_b = 16'hDCBA;
        for (int n = 0; n < 6; n++) begin
            idx = (n % 2 == 0) ? 1 : 3;
            oh = 4'(1) << idx;
            push_b(oh, 2'(idx), data_b[idx*4 +: 4]);
            step();
            chk("b2b_drained", 32'(qb.size()), 32'd0);
            chk("b2b_en", 32'(b_en), 32'd1);
            chk("b2b_busy", 32'(b_busy), 32'd0);
        end
        req_b = 4'b0000;
        step();
        chk("b2b_stop_en", 32'(b_en), 32'd0);
        chk("b2b_data_hold", 32'(b_data), 32'hD);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
